// File: rtl/systemizer_seq.sv
// Phase sequencer: walks the phase engine block by block through a left pass, optionally chaining a right pass.
// Optional feature macro: SYSTEMIZER_CYCLE_COUNT_EN adds a saturating run-length counter on the cycles port.
module systemizer_seq #(
  parameter int N       = 20,
  parameter int L       = 200,
  parameter int K       = 400,
  parameter int PASS2   = 0,
  parameter int TIMEOUT = 0,
  parameter int BW      = $clog2(K/N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          start_right,
  input  logic          abort,
  output logic          init_left,
  output logic          init_right,
  output logic          start_phase,
  output logic [BW-1:0] start_block,
  output logic          last_phase,
  input  logic          phase_done,
  input  logic          phase_fail,
  output logic [1:0]    gen_left_op,
  output logic [1:0]    gen_right_op,
  output logic          busy,
  output logic          done,
  output logic          success,
  output logic          fail,
  output logic [BW-1:0] fail_block
`ifdef SYSTEMIZER_CYCLE_COUNT_EN
  ,
  output logic [31:0]   cycles
`endif
);

  localparam int  NB_L   = (L + N - 1) / N;
  localparam int  NB_R   = (K - L + N - 1) / N;
  localparam int  LAST_L = (NB_L > 0) ? NB_L - 1 : 0;
  localparam int  LAST_R = (NB_R > 0) ? NB_R - 1 : 0;
  localparam bit  PART_L = (L % N) != 0;
  localparam bit  PART_R = ((K - L) % N) != 0;
  localparam int  WDW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int  TO_M1  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LAUNCH,
    S_WAIT,
    S_END
  } state_t;

  state_t         state_reg;
  logic           pass_right_reg;
  logic           check_reg;
  logic [WDW-1:0] wd_reg;
  logic           is_last;
  logic           wd_hit;

  assign gen_left_op  = 2'b01;
  assign gen_right_op = (PASS2 != 0) ? 2'b01 : 2'b00;

  assign is_last    = start_block == (pass_right_reg ? BW'(LAST_R) : BW'(LAST_L));
  assign last_phase = is_last && (pass_right_reg ? PART_R : PART_L);
  assign wd_hit     = (TIMEOUT != 0) && (wd_reg == WDW'(TO_M1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      pass_right_reg <= 1'b0;
      check_reg      <= 1'b0;
      wd_reg         <= '0;
      init_left      <= 1'b0;
      init_right     <= 1'b0;
      start_phase    <= 1'b0;
      start_block    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      success        <= 1'b0;
      fail           <= 1'b0;
      fail_block     <= '0;
    end else begin
      init_left   <= 1'b0;
      init_right  <= 1'b0;
      start_phase <= 1'b0;
      done        <= 1'b0;
      success     <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start || start_right) begin
            state_reg      <= S_INIT;
            busy           <= 1'b1;
            fail           <= 1'b0;
            fail_block     <= '0;
            pass_right_reg <= !start;
            check_reg      <= start;
            start_block    <= '0;
            init_left      <= start;
            init_right     <= !start;
          end
        end
        S_INIT: begin
          if (abort) begin
            state_reg  <= S_END;
            done       <= 1'b1;
            fail       <= 1'b1;
            fail_block <= start_block;
          end else begin
            state_reg   <= S_LAUNCH;
            start_phase <= 1'b1;
            wd_reg      <= '0;
          end
        end
        S_LAUNCH: begin
          if (abort) begin
            state_reg  <= S_END;
            done       <= 1'b1;
            fail       <= 1'b1;
            fail_block <= start_block;
          end else begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A silent engine past the watchdog limit is reported exactly like a singular pivot.
          if (abort || phase_fail || wd_hit) begin
            state_reg  <= S_END;
            done       <= 1'b1;
            fail       <= 1'b1;
            fail_block <= start_block;
          end else if (phase_done) begin
            if (!is_last) begin
              state_reg   <= S_LAUNCH;
              start_block <= start_block + 1'b1;
              start_phase <= 1'b1;
              wd_reg      <= '0;
            end else if (!pass_right_reg && (PASS2 != 0) && check_reg) begin
              state_reg      <= S_INIT;
              pass_right_reg <= 1'b1;
              start_block    <= '0;
              init_right     <= 1'b1;
            end else begin
              state_reg <= S_END;
              done      <= 1'b1;
              success   <= 1'b1;
            end
          end else if (TIMEOUT != 0) begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        S_END: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef SYSTEMIZER_CYCLE_COUNT_EN
  logic [31:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      cycles  <= '0;
    end else begin
      if (state_reg == S_IDLE && (start || start_right)) begin
        cnt_reg <= '0;
      end else if (busy && cnt_reg != 32'hFFFF_FFFF) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
      // The END cycle itself is still busy, so it is included in the frozen count.
      if (state_reg == S_END) begin
        cycles <= (cnt_reg == 32'hFFFF_FFFF) ? cnt_reg : cnt_reg + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systemizer_seq.sv
// Bench for systemizer_seq: four configurations share one stimulus bus selected by sel,
// driven by a randomized engine and checked against a block-list model built from the pass widths.
module tb_systemizer_seq;

  localparam int N  = 20;
  localparam int K  = 400;
  localparam int BW = 5;

  typedef struct {
    bit right;
    int blk;
    bit last;
  } ph_t;

  logic clk = 1'b0;
  logic rst, start_s, start_right_s, abort_s, phase_done_s, phase_fail_s;
  int   sel;

  logic [3:0]         il_v, ir_v, sp_v, lp_v, busy_v, done_v, succ_v, fail_v;
  logic [3:0][BW-1:0] sb_v, fb_v;
  logic [3:0][1:0]    glo_v, gro_v;
`ifdef SYSTEMIZER_CYCLE_COUNT_EN
  logic [3:0][31:0]   cyc_v;
`endif

  logic          il, ir, sp, lp, bz, dn, sc, fl;
  logic [BW-1:0] sb, fb;
  logic [1:0]    glo, gro;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    systemizer_seq #(
      .N(N), .L((gi == 1) ? 210 : 200), .K(K),
      .PASS2((gi == 2) ? 1 : 0), .TIMEOUT((gi == 3) ? 8 : 0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start_s && sel == gi),
      .start_right (start_right_s && sel == gi),
      .abort       (abort_s && sel == gi),
      .init_left   (il_v[gi]),
      .init_right  (ir_v[gi]),
      .start_phase (sp_v[gi]),
      .start_block (sb_v[gi]),
      .last_phase  (lp_v[gi]),
      .phase_done  (phase_done_s && sel == gi),
      .phase_fail  (phase_fail_s && sel == gi),
      .gen_left_op (glo_v[gi]),
      .gen_right_op(gro_v[gi]),
      .busy        (busy_v[gi]),
      .done        (done_v[gi]),
      .success     (succ_v[gi]),
      .fail        (fail_v[gi]),
      .fail_block  (fb_v[gi])
`ifdef SYSTEMIZER_CYCLE_COUNT_EN
      ,
      .cycles      (cyc_v[gi])
`endif
    );
  end

  always_comb begin
    il  = il_v[sel[1:0]];
    ir  = ir_v[sel[1:0]];
    sp  = sp_v[sel[1:0]];
    lp  = lp_v[sel[1:0]];
    bz  = busy_v[sel[1:0]];
    dn  = done_v[sel[1:0]];
    sc  = succ_v[sel[1:0]];
    fl  = fail_v[sel[1:0]];
    sb  = sb_v[sel[1:0]];
    fb  = fb_v[sel[1:0]];
    glo = glo_v[sel[1:0]];
    gro = gro_v[sel[1:0]];
  end

  function automatic int cfg_l(input int s);
    return (s == 1) ? 210 : 200;
  endfunction

  function automatic bit cfg_p2(input int s);
    return s == 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s sel=%0d observed=%0d expected=%0d", tag, sel, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, 32'({il, ir, sp, lp, bz, dn, sc, fl, sb, fb}), 32'd0);
  endtask

  // One complete run. The first nonnegative of fail_at/abort_at/silent_at (model index) ends the run early.
  task automatic run_one(input string tag, input bit use_right, input int fail_at,
                         input int abort_at, input int silent_at, input bit busy_start);
    ph_t q[$];
    ph_t p;
    int  lw, nbl, stop, exp_fb, exp_ir;
    int  seen, cd, cur, drive_cyc, sp_cyc, ir_cnt;
    bit  exp_fail, finished;
    lw  = cfg_l(sel);
    nbl = (lw + N - 1) / N;
    for (int pass = 0; pass < 2; pass++) begin
      int pw, nb;
      bit take;
      take = (pass == 0) ? !use_right : (use_right || cfg_p2(sel));
      pw   = (pass == 0) ? lw : K - lw;
      nb   = (pw + N - 1) / N;
      if (take) begin
        for (int b = 0; b < nb; b++) begin
          p.right = pass[0];
          p.blk   = b;
          p.last  = (b == nb - 1) && (pw % N != 0);
          q.push_back(p);
        end
      end
    end
    exp_fail = (fail_at >= 0) || (abort_at >= 0) || (silent_at >= 0);
    stop = (fail_at >= 0) ? fail_at : (abort_at >= 0) ? abort_at :
           (silent_at >= 0) ? silent_at : q.size() - 1;
    exp_fb = q[stop].blk;
    exp_ir = (!use_right && cfg_p2(sel) && stop >= nbl) ? 1 : 0;
    seen = 0; cd = 0; cur = -1; drive_cyc = -100; sp_cyc = 0; ir_cnt = 0; finished = 0;

    @(negedge clk);
    start_s       = !use_right;
    start_right_s = use_right;
    @(negedge clk);
    start_s       = 1'b0;
    start_right_s = 1'b0;
    check({tag, "_busy_on"}, 32'(bz), 32'd1);
    check({tag, "_init"}, 32'({il, ir}), use_right ? 32'd1 : 32'd2);
    check({tag, "_fail_clr"}, 32'(fl), 32'd0);

    for (int cyc = 0; cyc < 700 && !finished; cyc++) begin
      @(negedge clk);
      phase_done_s = 1'b0;
      phase_fail_s = 1'b0;
      abort_s      = 1'b0;
      start_s      = 1'b0;
      if (ir) begin
        ir_cnt++;
        check({tag, "_ir_pos"}, 32'(seen), 32'(nbl));
      end
      if (sp) begin
        if (seen == 0) check({tag, "_sp_latency"}, 32'(cyc), 32'd0);
        if (seen < q.size()) begin
          check({tag, "_blk"}, 32'(sb), 32'(q[seen].blk));
          check({tag, "_last"}, 32'(lp), 32'(q[seen].last));
        end else begin
          check({tag, "_extra_sp"}, 32'(seen), 32'(q.size() - 1));
        end
        cur    = seen;
        seen++;
        sp_cyc = cyc;
        cd     = (cur == silent_at) ? 0 : $urandom_range(2, 6);
      end else if (cd > 0) begin
        cd--;
        if (busy_start && cur == 1 && cd == 1) start_s = 1'b1;
        if (cd == 0) begin
          drive_cyc = cyc;
          if (cur == abort_at) abort_s = 1'b1;
          else if (cur == fail_at) begin
            phase_done_s = 1'b1;
            phase_fail_s = 1'b1;
          end else phase_done_s = 1'b1;
        end
      end
      if (dn) begin
        if (silent_at >= 0) check({tag, "_wd_latency"}, 32'(cyc - sp_cyc), 32'd9);
        else                check({tag, "_done_latency"}, 32'(cyc - drive_cyc), 32'd1);
        check({tag, "_success"}, 32'(sc), 32'(!exp_fail));
        check({tag, "_fail"}, 32'(fl), 32'(exp_fail));
        if (exp_fail) check({tag, "_fail_block"}, 32'(fb), 32'(exp_fb));
        check({tag, "_nphases"}, 32'(seen), 32'(stop + 1));
        check({tag, "_n_init_right"}, 32'(ir_cnt), 32'(exp_ir));
        @(negedge clk);
        check({tag, "_done_width"}, 32'({dn, sc, bz}), 32'd0);
        if (exp_fail) check({tag, "_fail_sticky"}, 32'(fl), 32'd1);
        finished = 1'b1;
        $display("run %s sel=%0d right=%0b phases=%0d fail=%0b fail_block=%0d",
                 tag, sel, use_right, seen, fl, fb);
      end
    end
    if (!finished) check({tag, "_run_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int blk, cd;
    bit reached, dn_seen;
    rst = 1'b1; start_s = 0; start_right_s = 0; abort_s = 0;
    phase_done_s = 0; phase_fail_s = 0; sel = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check_idle("reset_outputs");
      check("gen_left_op", 32'(glo), 32'd1);
      check("gen_right_op", 32'(gro), (s == 2) ? 32'd1 : 32'd0);
    end

    sel = 0; run_one("left_l200", 0, -1, -1, -1, 0);
    sel = 0; run_one("right_only", 1, -1, -1, -1, 0);
    sel = 1; run_one("left_l210", 0, -1, -1, -1, 0);
    sel = 0; run_one("fail_blk3", 0, 3, -1, -1, 0);
    sel = 0; run_one("restart", 0, -1, -1, -1, 0);
    sel = 2; run_one("pass2_chain", 0, -1, -1, -1, 0);
    sel = 3; run_one("watchdog", 0, -1, -1, 0, 0);
    sel = 3; run_one("abort_blk6", 0, -1, 6, -1, 0);
    sel = 0; run_one("start_busy", 0, -1, -1, -1, 1);
    for (int i = 0; i < 6; i++) begin
      int kind, idx;
      bit rgt;
      sel  = $urandom_range(0, 3);
      rgt  = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 2);
      idx  = $urandom_range(0, 9);
      if (kind == 0)      run_one("rand_ok", rgt, -1, -1, -1, 0);
      else if (kind == 1) run_one("rand_fail", rgt, idx, -1, -1, 0);
      else                run_one("rand_abort", rgt, -1, idx, -1, 0);
    end

    // Reset while waiting on block 2: everything returns to idle and no done appears.
    sel = 0; reached = 0; cd = 0; blk = -1; dn_seen = 0;
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
      @(negedge clk);
      phase_done_s = 1'b0;
      if (sp) begin
        blk = int'(sb);
        cd  = 3;
        if (blk == 2) reached = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) phase_done_s = 1'b1;
      end
    end
    check("rst_reach_blk2", 32'(reached), 32'd1);
    @(negedge clk);
    check("rst_pre_busy", 32'(bz), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_mid_outputs");
    repeat (20) begin
      @(negedge clk);
      dn_seen = dn_seen | dn;
    end
    check("rst_no_done", 32'(dn_seen), 32'd0);
    $display("run rst_mid sel=%0d reset in block %0d", sel, blk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
